width_8to16: RTL and testbench

- Width converter that packs two consecutive valid 8-bit input bytes into one 16-bit output word.
- The first byte of each pair becomes the upper byte and the second becomes the lower byte.
- Sits on a byte-wide streaming path feeding a 16-bit consumer.
- Output is registered and accompanied by a one-cycle valid strobe.

---
 rtl/width_8to16.sv | 72 +++++++
 tb/tb_width_8to16.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/width_8to16.sv
// Byte-to-word width converter: packs two consecutive valid bytes into one
// registered 16-bit word, first byte in the upper half, with a one-cycle
// valid strobe per completed word.
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | no byte held; next valid byte is the upper byte
// HALF  | upper byte held; next valid byte completes the word
//
// Note: rst_n is asynchronous and active-high despite its name; it is kept
// for compatibility with the surrounding byte-stream path.
module width_8to16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [7:0]  data_in,
   output logic        valid_out,
   output logic [15:0] data_out
);

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  hold_q;
   logic [7:0]  hold_d;
   logic [15:0] data_d;
   logic        valid_d;

   // State, holding byte and registered outputs; reset clears everything at once
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q   <= EMPTY;
         hold_q    <= 8'h00;
         data_out  <= 16'h0000;
         valid_out <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         data_out  <= data_d;
         valid_out <= valid_d;
      end
   end

   // Next-state and output decode; data_out only changes when a word completes
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      data_d  = data_out;
      valid_d = 1'b0;
      if (valid_in) begin
         case (state_q)
            EMPTY: begin
               hold_d  = data_in;
               state_d = HALF;
            end
            HALF: begin
               data_d  = {hold_q, data_in};
               valid_d = 1'b1;
               state_d = EMPTY;
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_width_8to16.sv
// Directed bench for width_8to16 with a queue scoreboard of expected words.
module tb_width_8to16;

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic [7:0]  data_in;
   logic        valid_out;
   logic [15:0] data_out;

   int          vectors;
   int          miscompares;

   logic [15:0] exp_q[$];
   logic        m_half;
   logic [7:0]  m_hold;
   logic [15:0] m_last;
   logic        m_valid;

   width_8to16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .valid_out (valid_out),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_half  = 1'b0;
      m_hold  = 8'h00;
      m_last  = 16'h0000;
      m_valid = 1'b0;
      exp_q.delete();
   endtask

   // Drive one cycle, advance the model, then compare just after the edge
   task automatic step(input logic v, input logic [7:0] d, input string tag);
      logic [15:0] w;
      valid_in = v;
      data_in  = d;
      m_valid  = 1'b0;
      if (v) begin
         if (!m_half) begin
            m_hold = d;
            m_half = 1'b1;
         end else begin
            exp_q.push_back({m_hold, d});
            m_half  = 1'b0;
            m_valid = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {15'd0, valid_out}, {15'd0, m_valid});
      if (m_valid) begin
         w = exp_q.pop_front();
         check({tag, "_word"}, data_out, w);
         m_last = w;
      end else begin
         check({tag, "_hold"}, data_out, m_last);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      valid_in    = 1'b0;
      data_in     = 8'h00;
      rst_n       = 1'b1;
      model_reset();

      // Reset held for two edges
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", data_out, 16'h0000);
      check("rst_valid", {15'd0, valid_out}, 16'h0000);
      rst_n = 1'b0;

      // Basic pair
      step(1'b1, 8'hA0, "basic0");
      step(1'b1, 8'hA1, "basic1");
      step(1'b0, 8'h55, "basic_after");

      // Gap inside a pair
      step(1'b1, 8'hB0, "gap0");
      step(1'b0, 8'hFF, "gap_idle");
      step(1'b0, 8'h12, "gap_idle");
      step(1'b0, 8'h34, "gap_idle");
      step(1'b1, 8'hB1, "gap1");
      step(1'b0, 8'h00, "gap_after");
      step(1'b0, 8'h00, "gap_after");

      // Back-to-back streaming
      for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), "stream");
      step(1'b0, 8'h00, "stream_after");

      // Reset while holding an upper byte discards it
      step(1'b1, 8'hC0, "mid0");
      valid_in = 1'b0;
      rst_n    = 1'b1;
      #1;
      check("mid_rst_data", data_out, 16'h0000);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      step(1'b1, 8'hD0, "post_rst0");
      step(1'b1, 8'hD1, "post_rst1");
      step(1'b0, 8'h00, "post_rst_after");

      // Idle with random data
      for (int i = 0; i < 10; i++) step(1'b0, 8'($urandom), "idle");

      // Asynchronous reset during a strobe clears outputs before any edge
      step(1'b1, 8'hE0, "strobe0");
      step(1'b1, 8'hE1, "strobe1");
      valid_in = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      check("async_valid", {15'd0, valid_out}, 16'h0000);
      check("async_data", data_out, 16'h0000);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      step(1'b1, 8'hF0, "final0");
      step(1'b1, 8'hF1, "final1");

      check("queue_empty", 16'(exp_q.size()), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
